// File: rtl/fn_suma_resta.sv
// -----------------------------------------------------------------------------
// fn_suma_resta
// Registered two's-complement adder/subtractor for the RV32I ALU ADD/SUB/ADDI
// path. With en high the operands are summed combinationally and Y, the status
// flags and a one-cycle valid strobe are registered on the same rising edge.
// The result is visible during the following cycle.
//
// Build option:
//   FN_SUMA_RESTA_FLAGS_EN  defined   -> carry/overflow/zero/negative computed
//                                        and registered
//                           undefined -> flag logic not built, flags tied to 0
//   Y, valid and latency are identical in both builds, as is the port list.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset (priority over en)
//   en        in   1      operation strobe, operands sampled when high
//   a         in   WIDTH  first operand (minuend)
//   b         in   WIDTH  second operand (subtrahend)
//   resta     in   1      0 = add, 1 = subtract
//   Y         out  WIDTH  registered result, modulo 2^WIDTH
//   valid     out  1      high for one cycle per new result
//   carry     out  1      carry out of MSB (subtract: 1 = no borrow)
//   overflow  out  1      signed overflow
//   zero      out  1      Y == 0
//   negative  out  1      Y[WIDTH-1]
// -----------------------------------------------------------------------------
module fn_suma_resta #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             resta,
    output logic [WIDTH-1:0] Y,
    output logic             valid,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // Subtraction as a + ~b + 1: invert b and inject resta as carry-in.
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    assign w_b_eff = b ^ {WIDTH{resta}};

`ifdef FN_SUMA_RESTA_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic           w_carry;
    logic           w_overflow;
    logic           w_zero;
    logic           r_carry;
    logic           r_overflow;
    logic           r_zero;
    logic           r_negative;

    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, resta};
    assign w_y     = w_sum[WIDTH-1:0];
    assign w_carry = w_sum[WIDTH];
    // Using the effective (possibly inverted) b covers both cases: add needs
    // same signs of a and b, subtract needs different signs.
    assign w_overflow = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_y[WIDTH-1] != a[WIDTH-1]);
    assign w_zero     = (w_y == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else if (en) begin
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
            r_zero     <= w_zero;
            r_negative <= w_y[WIDTH-1];
        end
    end

    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign negative = r_negative;
`else
    assign w_y = a + w_b_eff + {{(WIDTH-1){1'b0}}, resta};

    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= en;
            if (en) begin
                r_y <= w_y;
            end
        end
    end

    assign Y     = r_y;
    assign valid = r_valid;

endmodule

// File: tb/tb_fn_suma_resta.sv
module tb_fn_suma_resta;

    localparam int WIDTH = 32;
`ifdef FN_SUMA_RESTA_FLAGS_EN
    localparam logic [3:0] FLAG_MASK = 4'b1111;
`else
    localparam logic [3:0] FLAG_MASK = 4'b0000;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             resta;
    logic [WIDTH-1:0] Y;
    logic             valid;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed vector: operands, op, expected Y, expected {c,o,z,n}.
    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vr;
        logic [31:0] ey;
        logic [3:0]  ef;
    } vec_t;

    fn_suma_resta #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
        .b        (b),
        .resta    (resta),
        .Y        (Y),
        .valid    (valid),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic e, input logic [31:0] va, input logic [31:0] vb,
                         input logic vr);
        en    = e;
        a     = va;
        b     = vb;
        resta = vr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (Y !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_y: got %h expected %h", Y, 32'h0);
        end
        n_checks++;
        if ({valid, carry, overflow, zero, negative} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b",
                     {valid, carry, overflow, zero, negative}, 5'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(1'b1, 32'd15, 32'd10, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (Y !== 32'd25) begin
            n_fail++;
            $display("FAIL add_y: got %h expected %h", Y, 32'd25);
        end
        n_checks++;
        if ({valid, carry, overflow, zero, negative} !== {1'b1, 4'b0000 & FLAG_MASK}) begin
            n_fail++;
            $display("FAIL add_flags: got %b expected %b",
                     {valid, carry, overflow, zero, negative}, {1'b1, 4'b0000 & FLAG_MASK});
        end
        tick();
        n_checks++;
        if (Y !== 32'd25) begin
            n_fail++;
            $display("FAIL add_hold_y: got %h expected %h", Y, 32'd25);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_hold_valid: got %b expected %b", valid, 1'b0);
        end
    endtask

    // Each vector issued alone, followed by an idle cycle.
    task automatic test_vectors();
        vec_t v[9];
        v[0] = '{32'd15,        32'd10, 1'b1, 32'd5,         4'b1000};
        v[1] = '{32'd10,        32'd15, 1'b1, 32'hFFFF_FFFB, 4'b0001};
        v[2] = '{32'h7FFF_FFFF, 32'd1,  1'b0, 32'h8000_0000, 4'b0101};
        v[3] = '{32'h8000_0000, 32'd1,  1'b1, 32'h7FFF_FFFF, 4'b1100};
        v[4] = '{32'hFFFF_FFFF, 32'd1,  1'b0, 32'h0,         4'b1010};
        v[5] = '{32'd7,         32'd7,  1'b1, 32'h0,         4'b1010};
        v[6] = '{32'h1234_5678, 32'd0,  1'b1, 32'h1234_5678, 4'b1000};
        v[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0,  4'b1110};
        v[8] = '{32'h0,         32'd1,  1'b1, 32'hFFFF_FFFF, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, v[i].va, v[i].vb, v[i].vr);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            n_checks++;
            if (Y !== v[i].ey) begin
                n_fail++;
                $display("FAIL vec%0d_y: got %h expected %h", i, Y, v[i].ey);
            end
            n_checks++;
            if ({valid, carry, overflow, zero, negative} !== {1'b1, v[i].ef & FLAG_MASK}) begin
                n_fail++;
                $display("FAIL vec%0d_flags: got %b expected %b", i,
                         {valid, carry, overflow, zero, negative}, {1'b1, v[i].ef & FLAG_MASK});
            end
            tick();
            n_checks++;
            if ({Y, valid, carry, overflow, zero, negative} !==
                {v[i].ey, 1'b0, v[i].ef & FLAG_MASK}) begin
                n_fail++;
                $display("FAIL vec%0d_hold: got %h/%b expected %h/%b", i, Y,
                         {valid, carry, overflow, zero, negative},
                         v[i].ey, {1'b0, v[i].ef & FLAG_MASK});
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 32'd15, 32'd10, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_checks++;
        if (Y !== 32'd25) begin
            n_fail++;
            $display("FAIL rstpri_pre_y: got %h expected %h", Y, 32'd25);
        end
        rst = 1'b1;
        drive(1'b1, 32'd3, 32'd4, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (Y !== 32'h0) begin
            n_fail++;
            $display("FAIL rstpri_y: got %h expected %h", Y, 32'h0);
        end
        n_checks++;
        if ({valid, carry, overflow, zero, negative} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstpri_flags: got %b expected %b",
                     {valid, carry, overflow, zero, negative}, 5'b0);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        v[0] = '{32'd1, 32'd2, 1'b0, 32'd3,         4'b0000};
        v[1] = '{32'd9, 32'd4, 1'b1, 32'd5,         4'b1000};
        v[2] = '{32'd0, 32'd0, 1'b0, 32'd0,         4'b0010};
        v[3] = '{32'd5, 32'd6, 1'b1, 32'hFFFF_FFFF, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, v[i].va, v[i].vb, v[i].vr);
            tick();
            n_checks++;
            if (Y !== v[i].ey) begin
                n_fail++;
                $display("FAIL stream%0d_y: got %h expected %h", i, Y, v[i].ey);
            end
            n_checks++;
            if ({valid, carry, overflow, zero, negative} !== {1'b1, v[i].ef & FLAG_MASK}) begin
                n_fail++;
                $display("FAIL stream%0d_flags: got %b expected %b", i,
                         {valid, carry, overflow, zero, negative}, {1'b1, v[i].ef & FLAG_MASK});
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        n_checks++;
        if ({Y, valid} !== {32'hFFFF_FFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL stream_end: got %h/%b expected %h/%b", Y, valid, 32'hFFFF_FFFF, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_add();
        test_vectors();
        test_reset_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fn_suma_resta.md
Name: fn_suma_resta

Overview:
- Registered 32-bit two's-complement adder/subtractor for the RV32I datapath (ALU ADD/SUB/ADDI path).
- `resta` = 0 gives Y = a + b; `resta` = 1 gives Y = a − b.
- Operands are captured, the result is computed, and Y plus status flags are registered with one-cycle latency and a valid strobe.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  operation strobe; operands are sampled when high.
- a  input  WIDTH  first operand (minuend for subtraction).
- b  input  WIDTH  second operand (subtrahend for subtraction).
- resta  input  1  0 = add, 1 = subtract.
- Y  output  WIDTH  registered result, modulo 2^WIDTH.
- valid  output  1  high for exactly one cycle when Y holds a new result.
- carry  output  1  carry out of the MSB; for subtraction, 1 means no borrow (a ≥ b unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  Y == 0.
- negative  output  1  Y[WIDTH-1].

Behaviour:
- Reset, with rst high at a rising edge:
  - Y = 0, valid = 0, carry = 0, overflow = 0, zero = 0, negative = 0.
  - rst has priority over en.
- Core equation: sum = a + (b XOR {WIDTH{resta}}) + resta, computed WIDTH+1 bits wide.
  - Y = sum[WIDTH-1:0].
  - carry = sum[WIDTH].
- Overflow:
  - Add: a and b have the same sign and Y's sign differs from a.
  - Subtract: a and b have different signs and Y's sign differs from a.
- Latency:
  - If en = 1 at edge N, then Y, the flags and valid = 1 appear after edge N (visible during cycle N+1).
  - If en = 0 at an edge, Y and the flags hold their previous values and valid = 0.
- Back-to-back: en high on consecutive cycles yields a new result every cycle; valid stays high continuously.
- Wrap-around is silent (no exceptions): 0xFFFFFFFF + 1 gives Y = 0, carry = 1, zero = 1.
- Subtracting 0 gives Y = a and carry = 1.
- Reset asserted while en is high: the result is discarded; outputs go to their reset values on that edge.
- The arithmetic is purely combinational between the input sampling and the output register; there are no multicycle paths.
- Operands, resta and en are assumed to be synchronous to clk.

Optional Feature:
- Macro FN_SUMA_RESTA_FLAGS_EN.
- Defined: carry, overflow, zero and negative are computed and registered as specified.
- Undefined:
  - The flag logic is not built; the four flag outputs are tied to 0.
  - Y, valid and the latency are unchanged.
  - The port list is identical in both builds.

Test Plan:
- Add: rst pulse, then a = 15, b = 10, resta = 0, en = 1 for one cycle → next cycle Y = 25, valid = 1, carry = 0, overflow = 0, zero = 0; the cycle after, valid = 0 and Y holds 25.
- Subtract: a = 15, b = 10, resta = 1, en = 1 → Y = 5, carry = 1, negative = 0; then a = 10, b = 15, resta = 1 → Y = 0xFFFFFFFB, negative = 1, carry = 0.
- Signed overflow:
  - a = 0x7FFFFFFF, b = 1, resta = 0 → Y = 0x80000000, overflow = 1.
  - a = 0x80000000, b = 1, resta = 1 → Y = 0x7FFFFFFF, overflow = 1.
- Wrap and zero: a = 0xFFFFFFFF, b = 1, resta = 0 → Y = 0, carry = 1, zero = 1; a = 7, b = 7, resta = 1 → Y = 0, zero = 1, carry = 1.
- Reset priority: after a result Y = 25 is held, assert rst with en = 1, a = 3, b = 4 → next cycle Y = 0, valid = 0, all flags 0.
- Streaming: 4 consecutive en-high cycles with (1,2,add), (9,4,sub), (0,0,add), (5,6,sub) → Y = 3, 5, 0, 0xFFFFFFFF on successive cycles, with valid high for 4 cycles.
- With FN_SUMA_RESTA_FLAGS_EN undefined, the same stimulus gives identical Y and all flags 0.
